serial_slt_unit: RTL

SERIAL_SLT_UNIT -- requirements
Module: serial_slt_unit

---
 rtl/alu_pkg.sv | 12 +
 rtl/serial_slt_unit_cell.sv | 12 +
 rtl/serial_slt_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial comparator: FSM state encoding and default width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } slt_state_e;

endpackage

// File: rtl/serial_slt_unit_cell.sv
// One-bit less-than cell: folds one bit pair into the running lt-carry, LSB first.
module serial_slt_unit_cell (
  input  logic RS,
  input  logic RT,
  input  logic ltc,
  output logic RD
);

  // A higher bit decides on its own unless the two bits are equal.
  assign RD = (RT & ~RS) | (~(RS ^ RT) & ltc);

endmodule

// File: rtl/serial_slt_unit.sv
// Bit-serial SLT/SLTU: one operand bit per cycle, fixed WIDTH-cycle latency, registered outputs.
module serial_slt_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] RS,
  input  logic [WIDTH-1:0] RT,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] RD
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  slt_state_e       state_q, state_d;
  logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             sgn_q, sgn_d, ltc_q, ltc_d;

  logic last, swap, rs_bit, rt_bit, cell_rs, cell_rt, ltc_nx, accept;

  assign last   = (idx_q == IW'(WIDTH - 1));
  assign rs_bit = rs_q[idx_q];
  assign rt_bit = rt_q[idx_q];
  // Swapping the sign bits turns the unsigned recurrence into a two's complement compare.
  assign swap    = last & sgn_q;
  assign cell_rs = swap ? rt_bit : rs_bit;
  assign cell_rt = swap ? rs_bit : rt_bit;

  serial_slt_unit_cell u_cell (
    .RS  (cell_rs),
    .RT  (cell_rt),
    .ltc (ltc_q),
    .RD  (ltc_nx)
  );

  assign accept = start & ~flush;

  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    sgn_d   = sgn_q;
    ltc_d   = ltc_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          ltc_d = ltc_nx;
          if (last) begin
            state_d = DONE;
            idx_d   = '0;
            rd_d    = {{(WIDTH-1){1'b0}}, ltc_nx};
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          rs_d    = RS;
          rt_d    = RT;
          sgn_d   = is_signed;
          ltc_d   = 1'b0;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rs_q    <= '0;
      rt_q    <= '0;
      sgn_q   <= 1'b0;
      ltc_q   <= 1'b0;
      idx_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      sgn_q   <= sgn_d;
      ltc_q   <= ltc_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign RD   = rd_q;

endmodule
